// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file -- machine-mode control and status register file.
//
// Holds the trap-related CSRs (mstatus, mie, mtvec, mscratch, mepc, mcause),
// a registered copy of the interrupt inputs (mip), the counter inhibit mask,
// and 64-bit mcycle / minstret counters with read-only user shadows.
// The execute stage reads any CSR combinationally and may write, set or clear
// it in the same access. The interrupt controller (clint) has its own read
// port and a plain write port.
//
// Optional feature macro: CSR_HPM_EN
//   defined     -> NUM_HPM hardware performance counters (mhpmcounter3..),
//                  their user shadows and their inhibit bits are implemented.
//   not defined -> hpm addresses read as 0, ignore writes and are not illegal;
//                  hpm_event_i is ignored.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   ex_we_i, ex_op_i           ex write request and op (write/set/clear/none)
//   ex_addr_i, ex_data_i       ex address and write operand
//   ex_data_o, ex_illegal_o    pre-write value of ex_addr_i, illegal access
//   clint_we_i, clint_waddr_i  clint write strobe and write address
//   clint_raddr_i              clint read address
//   clint_data_i, clint_data_o clint write data, clint read data
//   retire_i                   one instruction retired this cycle
//   hpm_event_i                per-counter performance event strobes
//   irq_ext_i/timer_i/sw_i     raw interrupt levels
//   mtvec_o .. mip_o           register values
//   global_int_en_o            mstatus.MIE
//   int_pending_o              enabled interrupt pending and globally enabled
// ---------------------------------------------------------------------------
module csr_file #(
   parameter int XLEN    = 32,
   parameter int NUM_HPM = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ex_we_i,
   input  logic [1:0]          ex_op_i,
   input  logic [11:0]         ex_addr_i,
   input  logic [XLEN-1:0]     ex_data_i,
   output logic [XLEN-1:0]     ex_data_o,
   output logic                ex_illegal_o,
   input  logic                clint_we_i,
   input  logic [11:0]         clint_waddr_i,
   input  logic [11:0]         clint_raddr_i,
   input  logic [XLEN-1:0]     clint_data_i,
   output logic [XLEN-1:0]     clint_data_o,
   input  logic                retire_i,
   input  logic [NUM_HPM-1:0]  hpm_event_i,
   input  logic                irq_ext_i,
   input  logic                irq_timer_i,
   input  logic                irq_sw_i,
   output logic [XLEN-1:0]     mtvec_o,
   output logic [XLEN-1:0]     mepc_o,
   output logic [XLEN-1:0]     mstatus_o,
   output logic [XLEN-1:0]     mie_o,
   output logic [XLEN-1:0]     mip_o,
   output logic                global_int_en_o,
   output logic                int_pending_o
);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_SET   = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_NONE  = 2'b11;

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MIE       = 12'h304;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MCOUNTINH = 12'h320;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MIP       = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
   localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
   localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
   localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
   localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

`ifdef CSR_HPM_EN
   // Writable inhibit bits: CY, IR and one per implemented hpm counter.
   // The span is built in 64 bits so NUM_HPM = 29 does not overflow.
   localparam int          HPM_SLOTS    = (NUM_HPM > 0) ? NUM_HPM : 1;
   localparam logic [63:0] INHIBIT_SPAN = (64'd1 << (3 + NUM_HPM)) - 64'd1;
   localparam logic [31:0] INHIBIT_MASK = INHIBIT_SPAN[31:0] & 32'hFFFF_FFFD;
`else
   localparam logic [31:0] INHIBIT_MASK = 32'h0000_0005;
`endif

   logic [31:0] mstatus;
   logic [31:0] mie;
   logic [31:0] mtvec;
   logic [31:0] mcountinhibit;
   logic [31:0] mscratch;
   logic [31:0] mepc;
   logic [31:0] mcause;
   logic [31:0] mip;
   logic [63:0] mcycle;
   logic [63:0] minstret;
   logic [31:0] mip_sample;

`ifdef CSR_HPM_EN
   logic [63:0] hpm_count [HPM_SLOTS];
   logic [32:0] wr_hpm_lo [HPM_SLOTS];
   logic [32:0] wr_hpm_hi [HPM_SLOTS];

   // Selects one half of the hpm counter addressed by a counter-page offset;
   // offsets beyond the implemented counters read as zero.
   function automatic logic [31:0] hpm_value(input logic high, input logic [4:0] offset);
      logic [31:0] value;
      value = '0;
      for (int k = 0; k < NUM_HPM; k++) begin
         if (offset == 5'(k + 3)) begin
            value = high ? hpm_count[k][63:32] : hpm_count[k][31:0];
         end
      end
      return value;
   endfunction
`else
   logic unused_hpm;
   assign unused_hpm = ^hpm_event_i;
`endif

   // Shared read decoder. Bit 32 is the "implemented" flag, bits 31:0 the
   // value. The counter pages (0xB00, 0xB80, 0xC00, 0xC80) accept every
   // offset from 3 upward as an hpm slot, present or not.
   function automatic logic [32:0] csr_read(input logic [11:0] addr);
      logic [32:0] result;
      result = '0;
      case (addr)
         ADDR_MSTATUS:   result = {1'b1, mstatus};
         ADDR_MIE:       result = {1'b1, mie};
         ADDR_MTVEC:     result = {1'b1, mtvec};
         ADDR_MCOUNTINH: result = {1'b1, mcountinhibit};
         ADDR_MSCRATCH:  result = {1'b1, mscratch};
         ADDR_MEPC:      result = {1'b1, mepc};
         ADDR_MCAUSE:    result = {1'b1, mcause};
         ADDR_MIP:       result = {1'b1, mip};
         ADDR_MCYCLE:    result = {1'b1, mcycle[31:0]};
         ADDR_MCYCLEH:   result = {1'b1, mcycle[63:32]};
         ADDR_MINSTRET:  result = {1'b1, minstret[31:0]};
         ADDR_MINSTRETH: result = {1'b1, minstret[63:32]};
         ADDR_CYCLE:     result = {1'b1, mcycle[31:0]};
         ADDR_CYCLEH:    result = {1'b1, mcycle[63:32]};
         ADDR_INSTRET:   result = {1'b1, minstret[31:0]};
         ADDR_INSTRETH:  result = {1'b1, minstret[63:32]};
         ADDR_MHARTID:   result = {1'b1, 32'h0};
         default: begin
            if (((addr[11:5] == 7'h58) || (addr[11:5] == 7'h5C) ||
                 (addr[11:5] == 7'h60) || (addr[11:5] == 7'h64)) &&
                (addr[4:0] >= 5'd3)) begin
               result[32] = 1'b1;
`ifdef CSR_HPM_EN
               result[31:0] = hpm_value(addr[7], addr[4:0]);
`endif
            end
         end
      endcase
      return result;
   endfunction

   logic [32:0] ex_read;
   logic [32:0] clint_read;
   logic        ex_illegal;
   logic        ex_commit;
   logic [31:0] ex_new;
   logic        unused_clint_hit;

   // Both read ports share the decoder. The ex write value is derived from
   // the pre-write contents, so set/clear are atomic within one access.
   // Writes to the read-only space (top address bits 11) are illegal unless
   // the op is a pure read.
   always_comb begin
      ex_read    = csr_read(ex_addr_i);
      clint_read = csr_read(clint_raddr_i);
      ex_illegal = !ex_read[32] ||
                   (ex_we_i && (ex_op_i != OP_NONE) && (ex_addr_i[11:10] == 2'b11));
      ex_commit  = ex_we_i && (ex_op_i != OP_NONE) && !ex_illegal;
      ex_new     = ex_read[31:0];
      case (ex_op_i)
         OP_WRITE: ex_new = ex_data_i;
         OP_SET:   ex_new = ex_read[31:0] | ex_data_i;
         OP_CLEAR: ex_new = ex_read[31:0] & ~ex_data_i;
         default:  ex_new = ex_read[31:0];
      endcase
   end

   // Per-address write arbitration: ex takes priority over clint on the same
   // address, otherwise both ports may land in the same cycle.
   function automatic logic [32:0] write_sel(input logic [11:0] addr);
      if (ex_commit && (ex_addr_i == addr)) begin
         return {1'b1, ex_new};
      end
      if (clint_we_i && (clint_waddr_i == addr)) begin
         return {1'b1, clint_data_i};
      end
      return {1'b0, 32'h0};
   endfunction

   logic [32:0] wr_mstatus;
   logic [32:0] wr_mie;
   logic [32:0] wr_mtvec;
   logic [32:0] wr_minh;
   logic [32:0] wr_mscratch;
   logic [32:0] wr_mepc;
   logic [32:0] wr_mcause;
   logic [32:0] wr_mcycle_lo;
   logic [32:0] wr_mcycle_hi;
   logic [32:0] wr_minstret_lo;
   logic [32:0] wr_minstret_hi;

   // Write strobes and data for every writable register; the read-only
   // shadows, mip and mhartid are simply never decoded here.
   always_comb begin
      wr_mstatus     = write_sel(ADDR_MSTATUS);
      wr_mie         = write_sel(ADDR_MIE);
      wr_mtvec       = write_sel(ADDR_MTVEC);
      wr_minh        = write_sel(ADDR_MCOUNTINH);
      wr_mscratch    = write_sel(ADDR_MSCRATCH);
      wr_mepc        = write_sel(ADDR_MEPC);
      wr_mcause      = write_sel(ADDR_MCAUSE);
      wr_mcycle_lo   = write_sel(ADDR_MCYCLE);
      wr_mcycle_hi   = write_sel(ADDR_MCYCLEH);
      wr_minstret_lo = write_sel(ADDR_MINSTRET);
      wr_minstret_hi = write_sel(ADDR_MINSTRETH);
   end

   assign mip_sample = {20'b0, irq_ext_i, 3'b0, irq_timer_i, 3'b0, irq_sw_i, 3'b0};

   // Plain control registers. Hardwired-zero fields are masked on the way in
   // so every reader sees the architectural value. mip is a one-flop sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus       <= '0;
         mie           <= '0;
         mtvec         <= '0;
         mcountinhibit <= '0;
         mscratch      <= '0;
         mepc          <= '0;
         mcause        <= '0;
         mip           <= '0;
      end else begin
         if (wr_mstatus[32])  mstatus       <= wr_mstatus[31:0];
         if (wr_mie[32])      mie           <= wr_mie[31:0];
         if (wr_mtvec[32])    mtvec         <= {wr_mtvec[31:2], 2'b00};
         if (wr_minh[32])     mcountinhibit <= wr_minh[31:0] & INHIBIT_MASK;
         if (wr_mscratch[32]) mscratch      <= wr_mscratch[31:0];
         if (wr_mepc[32])     mepc          <= {wr_mepc[31:2], 2'b00};
         if (wr_mcause[32])   mcause        <= wr_mcause[31:0];
         mip <= mip_sample;
      end
   end

   // mcycle and minstret. A write to either half replaces only that half and
   // suppresses the increment for that cycle; otherwise they count unless
   // inhibited, wrapping naturally at 2^64.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcycle   <= '0;
         minstret <= '0;
      end else begin
         if (wr_mcycle_lo[32] || wr_mcycle_hi[32]) begin
            if (wr_mcycle_lo[32]) mcycle[31:0]  <= wr_mcycle_lo[31:0];
            if (wr_mcycle_hi[32]) mcycle[63:32] <= wr_mcycle_hi[31:0];
         end else if (!mcountinhibit[0]) begin
            mcycle <= mcycle + 64'd1;
         end

         if (wr_minstret_lo[32] || wr_minstret_hi[32]) begin
            if (wr_minstret_lo[32]) minstret[31:0]  <= wr_minstret_lo[31:0];
            if (wr_minstret_hi[32]) minstret[63:32] <= wr_minstret_hi[31:0];
         end else if (retire_i && !mcountinhibit[2]) begin
            minstret <= minstret + 64'd1;
         end
      end
   end

`ifdef CSR_HPM_EN
   // hpm counters follow the same write/increment rules as minstret, each
   // driven by its own event strobe and inhibit bit (3 + index).
   always_comb begin
      for (int k = 0; k < HPM_SLOTS; k++) begin
         wr_hpm_lo[k] = '0;
         wr_hpm_hi[k] = '0;
      end
      for (int k = 0; k < NUM_HPM; k++) begin
         wr_hpm_lo[k] = write_sel(12'(12'hB03 + k));
         wr_hpm_hi[k] = write_sel(12'(12'hB83 + k));
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_HPM; k++) begin
         if (rst) begin
            hpm_count[k] <= '0;
         end else if (wr_hpm_lo[k][32] || wr_hpm_hi[k][32]) begin
            if (wr_hpm_lo[k][32]) hpm_count[k][31:0]  <= wr_hpm_lo[k][31:0];
            if (wr_hpm_hi[k][32]) hpm_count[k][63:32] <= wr_hpm_hi[k][31:0];
         end else if (hpm_event_i[k] && !mcountinhibit[3 + k]) begin
            hpm_count[k] <= hpm_count[k] + 64'd1;
         end
      end
   end
`endif

   // clint sees its own write data when reading the address it is writing;
   // ex always sees the pre-write value.
   assign unused_clint_hit = clint_read[32];
   assign clint_data_o = (clint_we_i && (clint_waddr_i == clint_raddr_i)) ?
                         clint_data_i : clint_read[31:0];
   assign ex_data_o    = ex_read[31:0];
   assign ex_illegal_o = ex_illegal;

   assign mtvec_o         = mtvec;
   assign mepc_o          = mepc;
   assign mstatus_o       = mstatus;
   assign mie_o           = mie;
   assign mip_o           = mip;
   assign global_int_en_o = mstatus[3];
   assign int_pending_o   = (|(mie & mip)) & mstatus[3];

endmodule

// File: tb/tb_csr_file.sv
// ---------------------------------------------------------------------------
// tb_csr_file -- directed self-checking bench for csr_file.
// Inputs change 1 ns after the rising edge; outputs are sampled a further
// 1 ns later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_csr_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_we_i;
   logic [1:0]  ex_op_i;
   logic [11:0] ex_addr_i;
   logic [31:0] ex_data_i;
   logic [31:0] ex_data_o;
   logic        ex_illegal_o;
   logic        clint_we_i;
   logic [11:0] clint_waddr_i;
   logic [11:0] clint_raddr_i;
   logic [31:0] clint_data_i;
   logic [31:0] clint_data_o;
   logic        retire_i;
   logic [3:0]  hpm_event_i;
   logic        irq_ext_i;
   logic        irq_timer_i;
   logic        irq_sw_i;
   logic [31:0] mtvec_o;
   logic [31:0] mepc_o;
   logic [31:0] mstatus_o;
   logic [31:0] mie_o;
   logic [31:0] mip_o;
   logic        global_int_en_o;
   logic        int_pending_o;

   int checks = 0;
   int passed = 0;

`ifdef CSR_HPM_EN
   localparam logic [31:0] EXP_INHIBIT_ALL = 32'h0000_007D;
   localparam logic [31:0] EXP_HPM2_WRITE  = 32'h0000_0005;
   localparam logic [31:0] EXP_HPM0_EVENTS = 32'h0000_0002;
`else
   localparam logic [31:0] EXP_INHIBIT_ALL = 32'h0000_0005;
   localparam logic [31:0] EXP_HPM2_WRITE  = 32'h0000_0000;
   localparam logic [31:0] EXP_HPM0_EVENTS = 32'h0000_0000;
`endif

   csr_file dut (
      .clk            (clk),
      .rst            (rst),
      .ex_we_i        (ex_we_i),
      .ex_op_i        (ex_op_i),
      .ex_addr_i      (ex_addr_i),
      .ex_data_i      (ex_data_i),
      .ex_data_o      (ex_data_o),
      .ex_illegal_o   (ex_illegal_o),
      .clint_we_i     (clint_we_i),
      .clint_waddr_i  (clint_waddr_i),
      .clint_raddr_i  (clint_raddr_i),
      .clint_data_i   (clint_data_i),
      .clint_data_o   (clint_data_o),
      .retire_i       (retire_i),
      .hpm_event_i    (hpm_event_i),
      .irq_ext_i      (irq_ext_i),
      .irq_timer_i    (irq_timer_i),
      .irq_sw_i       (irq_sw_i),
      .mtvec_o        (mtvec_o),
      .mepc_o         (mepc_o),
      .mstatus_o      (mstatus_o),
      .mie_o          (mie_o),
      .mip_o          (mip_o),
      .global_int_en_o(global_int_en_o),
      .int_pending_o  (int_pending_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      ex_we_i       = 1'b0;
      ex_op_i       = 2'b11;
      ex_addr_i     = 12'h300;
      ex_data_i     = '0;
      clint_we_i    = 1'b0;
      clint_waddr_i = 12'h000;
      clint_raddr_i = 12'h300;
      clint_data_i  = '0;
      retire_i      = 1'b0;
      hpm_event_i   = '0;
      irq_ext_i     = 1'b0;
      irq_timer_i   = 1'b0;
      irq_sw_i      = 1'b0;
   endtask

   task automatic ex_access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data);
      ex_we_i   = 1'b1;
      ex_op_i   = op;
      ex_addr_i = addr;
      ex_data_i = data;
   endtask

   task automatic clint_write(input logic [11:0] addr, input logic [31:0] data);
      clint_we_i    = 1'b1;
      clint_waddr_i = addr;
      clint_data_i  = data;
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1'b1;
      ex_access(2'b00, 12'h304, 32'hFFF);
      retire_i    = 1'b1;
      irq_timer_i = 1'b1;
      tick();
      tick();
      set_idle();
      rst = 1'b0;
      ex_addr_i     = 12'hB00;
      clint_raddr_i = 12'h304;
      #1;
      checks++; if (ex_data_o !== 32'h0) $display("[TB] FAIL reset_mcycle: got %h expected %h", ex_data_o, 32'h0); else passed++;
      checks++; if (clint_data_o !== 32'h0) $display("[TB] FAIL reset_mie_read: got %h expected %h", clint_data_o, 32'h0); else passed++;
      checks++; if ({mstatus_o, mie_o, mtvec_o, mepc_o, mip_o} !== 160'h0) $display("[TB] FAIL reset_regs: got %h %h %h %h %h expected all 0", mstatus_o, mie_o, mtvec_o, mepc_o, mip_o); else passed++;
      checks++; if ({global_int_en_o, int_pending_o} !== 2'b00) $display("[TB] FAIL reset_int: got %b expected %b", {global_int_en_o, int_pending_o}, 2'b00); else passed++;
      repeat (10) tick();
      clint_raddr_i = 12'hC00;
      #1;
      checks++; if (ex_data_o !== 32'd10) $display("[TB] FAIL idle_mcycle: got %h expected %h", ex_data_o, 32'd10); else passed++;
      checks++; if (clint_data_o !== 32'd10) $display("[TB] FAIL idle_cycle_shadow: got %h expected %h", clint_data_o, 32'd10); else passed++;
      ex_addr_i = 12'h300;
      #1;
      checks++; if ({ex_illegal_o, ex_data_o} !== 33'h0) $display("[TB] FAIL mstatus_legal: got %b/%h expected 0/0", ex_illegal_o, ex_data_o); else passed++;
      ex_addr_i = 12'hB02;
      #1;
      checks++; if (ex_data_o !== 32'h0) $display("[TB] FAIL reset_minstret: got %h expected %h", ex_data_o, 32'h0); else passed++;
      ex_addr_i = 12'hF14;
      #1;
      checks++; if ({ex_illegal_o, ex_data_o} !== 33'h0) $display("[TB] FAIL mhartid: got %b/%h expected 0/0", ex_illegal_o, ex_data_o); else passed++;
   endtask

   task automatic test_set_clear();
      ex_access(2'b00, 12'h304, 32'h0);
      #1;
      checks++; if (ex_data_o !== 32'h0) $display("[TB] FAIL mie_write_old: got %h expected %h", ex_data_o, 32'h0); else passed++;
      tick();
      ex_access(2'b01, 12'h304, 32'h888);
      #1;
      checks++; if (ex_data_o !== 32'h0) $display("[TB] FAIL mie_set_old: got %h expected %h", ex_data_o, 32'h0); else passed++;
      tick();
      ex_access(2'b10, 12'h304, 32'h008);
      #1;
      checks++; if (ex_data_o !== 32'h888) $display("[TB] FAIL mie_clear_old: got %h expected %h", ex_data_o, 32'h888); else passed++;
      tick();
      ex_access(2'b11, 12'h304, 32'hFFF);
      #1;
      checks++; if (ex_data_o !== 32'h880) $display("[TB] FAIL mie_final_read: got %h expected %h", ex_data_o, 32'h880); else passed++;
      tick();
      set_idle();
      #1;
      checks++; if (mie_o !== 32'h880) $display("[TB] FAIL mie_after_pure_read: got %h expected %h", mie_o, 32'h880); else passed++;
   endtask

   task automatic test_counter_wrap();
      ex_access(2'b00, 12'hB00, 32'hFFFF_FFFF);
      tick();
      ex_access(2'b00, 12'hB80, 32'hFFFF_FFFF);
      tick();
      set_idle();
      ex_addr_i     = 12'hB00;
      clint_raddr_i = 12'hB80;
      #1;
      checks++; if ({clint_data_o, ex_data_o} !== 64'hFFFF_FFFF_FFFF_FFFF) $display("[TB] FAIL mcycle_max: got %h_%h expected FFFFFFFF_FFFFFFFF", clint_data_o, ex_data_o); else passed++;
      tick();
      checks++; if ({clint_data_o, ex_data_o} !== 64'h0) $display("[TB] FAIL mcycle_wrap: got %h_%h expected 0", clint_data_o, ex_data_o); else passed++;
   endtask

   task automatic test_inhibit();
      ex_access(2'b00, 12'h320, 32'hFFFF_FFFF);
      tick();
      set_idle();
      ex_addr_i = 12'h320;
      #1;
      checks++; if (ex_data_o !== EXP_INHIBIT_ALL) $display("[TB] FAIL inhibit_mask: got %h expected %h", ex_data_o, EXP_INHIBIT_ALL); else passed++;
      ex_access(2'b00, 12'h320, 32'h4);
      tick();
      set_idle();
      retire_i = 1'b1;
      repeat (5) tick();
      retire_i  = 1'b0;
      ex_addr_i = 12'hB02;
      #1;
      checks++; if (ex_data_o !== 32'h0) $display("[TB] FAIL minstret_inhibited: got %h expected %h", ex_data_o, 32'h0); else passed++;
      ex_access(2'b00, 12'h320, 32'h0);
      tick();
      set_idle();
      retire_i = 1'b1;
      repeat (3) tick();
      retire_i      = 1'b0;
      ex_addr_i     = 12'hB02;
      clint_raddr_i = 12'hC02;
      #1;
      checks++; if (ex_data_o !== 32'd3) $display("[TB] FAIL minstret_count: got %h expected %h", ex_data_o, 32'd3); else passed++;
      checks++; if (clint_data_o !== 32'd3) $display("[TB] FAIL instret_shadow: got %h expected %h", clint_data_o, 32'd3); else passed++;
   endtask

   task automatic test_same_cycle();
      ex_access(2'b00, 12'h341, 32'h100);
      clint_write(12'h341, 32'h200);
      clint_raddr_i = 12'h341;
      #1;
      checks++; if (clint_data_o !== 32'h200) $display("[TB] FAIL clint_bypass: got %h expected %h", clint_data_o, 32'h200); else passed++;
      checks++; if (ex_data_o !== 32'h0) $display("[TB] FAIL ex_no_bypass: got %h expected %h", ex_data_o, 32'h0); else passed++;
      tick();
      set_idle();
      #1;
      checks++; if (mepc_o !== 32'h100) $display("[TB] FAIL mepc_ex_wins: got %h expected %h", mepc_o, 32'h100); else passed++;
      ex_access(2'b00, 12'h340, 32'hAAAA_5555);
      clint_write(12'h342, 32'h8000_000B);
      tick();
      set_idle();
      ex_addr_i     = 12'h340;
      clint_raddr_i = 12'h342;
      #1;
      checks++; if (ex_data_o !== 32'hAAAA_5555) $display("[TB] FAIL mscratch_commit: got %h expected %h", ex_data_o, 32'hAAAA_5555); else passed++;
      checks++; if (clint_data_o !== 32'h8000_000B) $display("[TB] FAIL mcause_commit: got %h expected %h", clint_data_o, 32'h8000_000B); else passed++;
      ex_access(2'b00, 12'h341, 32'h0000_0207);
      clint_write(12'h305, 32'hFFFF_FFFF);
      tick();
      set_idle();
      #1;
      checks++; if (mepc_o !== 32'h204) $display("[TB] FAIL mepc_mask: got %h expected %h", mepc_o, 32'h204); else passed++;
      checks++; if (mtvec_o !== 32'hFFFF_FFFC) $display("[TB] FAIL mtvec_mask: got %h expected %h", mtvec_o, 32'hFFFF_FFFC); else passed++;
      clint_write(12'hF14, 32'h5);
      clint_raddr_i = 12'h300;
      tick();
      set_idle();
      clint_raddr_i = 12'hF14;
      #1;
      checks++; if (clint_data_o !== 32'h0) $display("[TB] FAIL clint_ro_ignored: got %h expected %h", clint_data_o, 32'h0); else passed++;
   endtask

   task automatic test_illegal();
      ex_access(2'b00, 12'hB00, 32'h1234);
      clint_write(12'h320, 32'h1);
      tick();
      set_idle();
      tick();
      ex_addr_i = 12'hB00;
      #1;
      checks++; if (ex_data_o !== 32'h1234) $display("[TB] FAIL mcycle_held: got %h expected %h", ex_data_o, 32'h1234); else passed++;
      ex_access(2'b00, 12'hC00, 32'hDEAD);
      #1;
      checks++; if (ex_illegal_o !== 1'b1) $display("[TB] FAIL cycle_write_illegal: got %b expected %b", ex_illegal_o, 1'b1); else passed++;
      tick();
      set_idle();
      ex_addr_i = 12'hC00;
      #1;
      checks++; if ({ex_illegal_o, ex_data_o} !== {1'b0, 32'h1234}) $display("[TB] FAIL cycle_unchanged: got %b/%h expected 0/00001234", ex_illegal_o, ex_data_o); else passed++;
      ex_addr_i = 12'h7C0;
      #1;
      checks++; if ({ex_illegal_o, ex_data_o} !== {1'b1, 32'h0}) $display("[TB] FAIL unimpl_7c0: got %b/%h expected 1/00000000", ex_illegal_o, ex_data_o); else passed++;
      ex_addr_i = 12'hB01;
      #1;
      checks++; if (ex_illegal_o !== 1'b1) $display("[TB] FAIL unimpl_b01: got %b expected %b", ex_illegal_o, 1'b1); else passed++;
      ex_access(2'b01, 12'hF14, 32'h1);
      #1;
      checks++; if (ex_illegal_o !== 1'b1) $display("[TB] FAIL set_mhartid: got %b expected %b", ex_illegal_o, 1'b1); else passed++;
      ex_access(2'b11, 12'hC00, 32'h1);
      #1;
      checks++; if (ex_illegal_o !== 1'b0) $display("[TB] FAIL pure_read_ro: got %b expected %b", ex_illegal_o, 1'b0); else passed++;
      ex_access(2'b00, 12'hB05, 32'h5);
      #1;
      checks++; if (ex_illegal_o !== 1'b0) $display("[TB] FAIL hpm_write_legal: got %b expected %b", ex_illegal_o, 1'b0); else passed++;
      tick();
      set_idle();
      ex_addr_i = 12'hB05;
      #1;
      checks++; if (ex_data_o !== EXP_HPM2_WRITE) $display("[TB] FAIL hpm2_value: got %h expected %h", ex_data_o, EXP_HPM2_WRITE); else passed++;
      hpm_event_i = 4'b0001;
      repeat (2) tick();
      hpm_event_i   = 4'b0000;
      clint_raddr_i = 12'hC03;
      #1;
      checks++; if (clint_data_o !== EXP_HPM0_EVENTS) $display("[TB] FAIL hpm0_events: got %h expected %h", clint_data_o, EXP_HPM0_EVENTS); else passed++;
   endtask

   task automatic test_interrupts();
      ex_access(2'b00, 12'h304, 32'h80);
      tick();
      ex_access(2'b00, 12'h300, 32'h8);
      tick();
      set_idle();
      #1;
      checks++; if ({mstatus_o, global_int_en_o, int_pending_o} !== {32'h8, 1'b1, 1'b0}) $display("[TB] FAIL mie_enabled: got %h/%b/%b expected 00000008/1/0", mstatus_o, global_int_en_o, int_pending_o); else passed++;
      irq_timer_i = 1'b1;
      #1;
      checks++; if ({mip_o, int_pending_o} !== {32'h0, 1'b0}) $display("[TB] FAIL irq_not_yet: got %h/%b expected 00000000/0", mip_o, int_pending_o); else passed++;
      tick();
      checks++; if ({mip_o, int_pending_o} !== {32'h80, 1'b1}) $display("[TB] FAIL timer_pending: got %h/%b expected 00000080/1", mip_o, int_pending_o); else passed++;
      irq_ext_i = 1'b1;
      tick();
      checks++; if (mip_o !== 32'h880) $display("[TB] FAIL mip_ext_timer: got %h expected %h", mip_o, 32'h880); else passed++;
      irq_ext_i   = 1'b0;
      irq_timer_i = 1'b0;
      irq_sw_i    = 1'b1;
      tick();
      checks++; if ({mip_o, int_pending_o} !== {32'h8, 1'b0}) $display("[TB] FAIL sw_masked: got %h/%b expected 00000008/0", mip_o, int_pending_o); else passed++;
      irq_sw_i = 1'b0;
      tick();
      checks++; if (mip_o !== 32'h0) $display("[TB] FAIL mip_clear: got %h expected %h", mip_o, 32'h0); else passed++;
   endtask

   initial begin
      set_idle();
      rst = 1'b1;
      $display("[TB] csr_file directed test start");
      test_reset();
      test_set_clear();
      test_counter_wrap();
      test_inhibit();
      test_same_cycle();
      test_illegal();
      test_interrupts();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/csr_file.md
# csr_file

Parametrised machine-mode CSR file for the core, successor to the fixed-register CSR block. Sits between `ex` (CSR instructions) and `clint` (trap entry/exit). Adds atomic read-modify-write ops, 64-bit mcycle/minstret plus optional hardware performance counters with per-counter inhibit, a registered `mip`, and illegal-access flagging.

## Interface
- `XLEN`, 32, data width; only 32 is supported.
- `NUM_HPM`, 4, number of mhpmcounters (index 3..3+NUM_HPM-1), range 0..29.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `ex_we_i`  in  1  ex CSR write request.
- `ex_op_i`  in  2  00 write, 01 set (OR), 10 clear (AND-NOT), 11 no write.
- `ex_addr_i`  in  12  ex CSR address (read and write).
- `ex_data_i`  in  XLEN  ex write operand.
- `ex_data_o`  out  XLEN  current (pre-write) value of `ex_addr_i`.
- `ex_illegal_o`  out  1  access is illegal.
- `clint_we_i`  in  1  clint write.
- `clint_waddr_i` / `clint_raddr_i`  in  12  clint write/read address.
- `clint_data_i`  in  XLEN  clint write data (plain write).
- `clint_data_o`  out  XLEN  clint read data.
- `retire_i`  in  1  one instruction retired this cycle.
- `hpm_event_i`  in  NUM_HPM  per-counter event strobe.
- `irq_ext_i`, `irq_timer_i`, `irq_sw_i`  in  1  raw interrupt levels.
- `mtvec_o`, `mepc_o`, `mstatus_o`, `mie_o`, `mip_o`  out  XLEN  register values.
- `global_int_en_o`  out  1  `mstatus[3]`.
- `int_pending_o`  out  1  `|(mie & mip) & mstatus[3]`.

## Operation
- Registers: mstatus 0x300, mie 0x304, mtvec 0x305, mcountinhibit 0x320, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (read-only), mcycle/h 0xB00/0xB80, minstret/h 0xB02/0xB82, mhpmcounterN/h 0xB00+N/0xB80+N, user shadows cycle/instret/hpmcounter at 0xC00../0xC80.. (read-only), mhartid 0xF14 (reads 0).
- Write masks: `mtvec[1:0]`, `mepc[1:0]` hardwired 0; mip = {20'b0, ext@11, 3'b0, timer@7, 3'b0, sw@3, 3'b0}; `mcountinhibit[1]` hardwired 0, bits above 2+NUM_HPM hardwired 0.
- ex new value: write d; set old|d; clear old&~d; op 11 writes nothing (pure read).
- `ex_illegal_o` = 1 when `ex_addr_i` unimplemented, or (`ex_we_i` & op≠11 & `ex_addr_i[11:10]==2'b11`). Illegal accesses never modify state; `ex_data_o` = 0 when unimplemented.
- clint accesses are never flagged; clint write to a read-only/unimplemented address is ignored.
- Same-cycle writes: different addresses both commit; same address, ex wins.
- clint read bypass: `clint_data_o` returns `clint_data_i` when `clint_we_i` and addresses equal; ex read has no bypass (returns old value).
- Counters: each 64-bit, increments by 1 per enabling event (mcycle every cycle, minstret on `retire_i`, hpmN on `hpm_event_i[N-3]`) unless its mcountinhibit bit is set. Wraps 2^64-1 → 0. Write to either half replaces that half; counter does not increment that cycle, other half untouched.
- mip samples irq inputs every cycle (one flop).

## Timing
- Reads combinational, same cycle. Writes and counters update at `posedge clk`.
- Write visible on `ex_data_o`/outputs the cycle after.
- Interrupt input → `mip_o`/`int_pending_o`: 1 cycle.
- Reset: all registers, counters, mip = 0; hence every register output 0, `global_int_en_o`=0, `int_pending_o`=0. Reset wins over any same-cycle write/increment; counting resumes the first cycle after reset deasserts (mcycle=1 one cycle later).

## Configuration
- `CSR_HPM_EN` defined: NUM_HPM mhpmcounters and their shadows/inhibit bits implemented.
- Not defined: no hpm flops; hpm addresses 0xB03..0xB1F/0xB83..0xB9F read 0, writes ignored, not illegal; user hpm shadows read 0; `hpm_event_i` ignored; `mcountinhibit[31:3]` hardwired 0.

## Test plan
- Reset, then 10 idle cycles → mcycle reads 10, all other CSRs 0, `ex_illegal_o`=0 for 0x300.
- mie=0x0 then ex set 0x888 then clear 0x008 → `ex_data_o` returns 0x000, 0x888 on successive ops; final mie=0x880.
- mcycle write 0xFFFFFFFF, mcycleh 0xFFFFFFFF → next cycle 0xFFFFFFFF_FFFFFFFF, following cycle 0 (wrap).
- mcountinhibit=0x4, pulse `retire_i` 5 times → minstret 0; clear inhibit, 3 pulses → 3.
- Same cycle ex write mepc=0x100, clint write mepc=0x200 → mepc=0x100; ex mscratch + clint mcause both commit.
- ex write 0xC00 → `ex_illegal_o`=1, cycle unchanged; read 0x7C0 → illegal, data 0; mie=0x80, mstatus=0x8, raise `irq_timer_i` → `int_pending_o`=1 one cycle later.
